// File: rtl/ws2812b_pkg.sv
// WS2812B timing at 27 MHz, shared by the transmitter and the receiver.
// Holds bit/reset timings, receiver decode thresholds and the receiver state encoding.
package ws2812b_pkg;

  // Transmit-side bit timings in 27 MHz cycles
  localparam int T0H = 9;
  localparam int T0L = 22;
  localparam int T1H = 19;
  localparam int T1L = 16;
  localparam int RES = 1080;

  // Receiver decode thresholds in 27 MHz cycles
  localparam int T_BIT_THRESH = 14;
  localparam int T_HIGH_MIN   = 4;
  localparam int T_HIGH_MAX   = 40;
  localparam int RES_DET      = 1080;
  localparam int CNT_W        = 11;

  localparam int PIXEL_BITS = 24;

  typedef enum logic [1:0] {
    WAIT_RESET = 2'd0,
    IDLE       = 2'd1,
    HIGH       = 2'd2,
    LOW        = 2'd3
  } rx_state_t;

  function automatic int bit_high_cycles(input logic b);
    return b ? T1H : T0H;
  endfunction

  function automatic int bit_low_cycles(input logic b);
    return b ? T1L : T0L;
  endfunction

endpackage

// File: rtl/ws2812b_rx_sync.sv
// Brings the asynchronous line into clk with two flops and flags its edges.
// din_s lags din by 2 cycles; rise/fall are combinational from din_s and its 1-cycle delay.
module ws2812b_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic din_s,
  output logic rise,
  output logic fall
);

  logic din_meta;
  logic din_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      din_meta <= 1'b0;
      din_s    <= 1'b0;
      din_d    <= 1'b0;
    end else begin
      din_meta <= din;
      din_s    <= din_meta;
      din_d    <= din_s;
    end
  end

  assign rise = din_s & ~din_d;
  assign fall = ~din_s & din_d;

endmodule

// File: rtl/ws2812b_rx.sv
// WS2812B receiver node: decodes the first 24 bits of a frame into a GRB pixel and forwards the rest.
// Pixel/status pulses appear one cycle after the deciding line edge; din to dout is 3 cycles; no backpressure.
module ws2812b_rx #(
  parameter int T_BIT_THRESH = ws2812b_pkg::T_BIT_THRESH,
  parameter int T_HIGH_MIN   = ws2812b_pkg::T_HIGH_MIN,
  parameter int T_HIGH_MAX   = ws2812b_pkg::T_HIGH_MAX,
  parameter int RES_DET      = ws2812b_pkg::RES_DET,
  parameter int CNT_W        = ws2812b_pkg::CNT_W
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        din,
  output logic        dout,
  output logic [23:0] pixel_data,
  output logic        pixel_valid,
  output logic        frame_end,
  output logic        err,
  output logic        rx_active
);

  import ws2812b_pkg::*;

  localparam logic [CNT_W-1:0] BIT_THRESH = CNT_W'(T_BIT_THRESH);
  localparam logic [CNT_W-1:0] HIGH_MIN   = CNT_W'(T_HIGH_MIN);
  localparam logic [CNT_W-1:0] HIGH_MAX   = CNT_W'(T_HIGH_MAX);
  localparam logic [CNT_W-1:0] LOW_END    = CNT_W'(RES_DET - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [4:0]       PIX_BITS   = 5'(PIXEL_BITS);
  localparam logic [4:0]       LAST_BIT   = 5'(PIXEL_BITS - 1);

  logic din_s;
  logic rise;
  logic fall;

  rx_state_t        state;
  logic [CNT_W-1:0] hi_cnt;
  logic [CNT_W-1:0] lo_cnt;
  logic [4:0]       bit_cnt;
  logic [22:0]      shreg;
  logic             fwd;
  logic             rx_bit;

  ws2812b_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (din),
    .din_s (din_s),
    .rise  (rise),
    .fall  (fall)
  );

  assign rx_bit = (hi_cnt >= BIT_THRESH);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= WAIT_RESET;
      hi_cnt      <= '0;
      lo_cnt      <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      fwd         <= 1'b0;
      dout        <= 1'b0;
      pixel_data  <= '0;
      pixel_valid <= 1'b0;
      frame_end   <= 1'b0;
      err         <= 1'b0;
      rx_active   <= 1'b0;
    end else begin
      pixel_valid <= 1'b0;
      frame_end   <= 1'b0;
      err         <= 1'b0;
      dout        <= fwd & din_s;

      case (state)
        // Wait out a full reset gap so decoding never starts inside a frame
        WAIT_RESET: begin
          if (din_s) begin
            lo_cnt <= '0;
          end else if (lo_cnt >= LOW_END) begin
            state <= IDLE;
          end else begin
            lo_cnt <= lo_cnt + 1'b1;
          end
        end

        IDLE: begin
          if (rise) begin
            state     <= HIGH;
            hi_cnt    <= CNT_ONE;
            rx_active <= 1'b1;
          end
        end

        HIGH: begin
          if (hi_cnt >= HIGH_MAX) begin
            err       <= 1'b1;
            rx_active <= 1'b0;
            fwd       <= 1'b0;
            bit_cnt   <= '0;
            lo_cnt    <= '0;
            state     <= WAIT_RESET;
          end else if (fall) begin
            if (hi_cnt < HIGH_MIN) begin
              err <= 1'b1;
            end else if (bit_cnt < PIX_BITS) begin
              shreg   <= {shreg[21:0], rx_bit};
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == LAST_BIT) begin
                pixel_data  <= {shreg, rx_bit};
                pixel_valid <= 1'b1;
                fwd         <= 1'b1;
              end
            end
            lo_cnt <= CNT_ONE;
            state  <= LOW;
          end else begin
            hi_cnt <= hi_cnt + 1'b1;
          end
        end

        LOW: begin
          if (rise) begin
            state  <= HIGH;
            hi_cnt <= CNT_ONE;
          end else if (lo_cnt >= LOW_END) begin
            frame_end <= 1'b1;
            rx_active <= 1'b0;
            fwd       <= 1'b0;
            // A frame cut short before a full pixel is a protocol error
            if (bit_cnt != '0 && bit_cnt < PIX_BITS) begin
              err <= 1'b1;
            end
            bit_cnt <= '0;
            state   <= IDLE;
          end else begin
            lo_cnt <= lo_cnt + 1'b1;
          end
        end

        default: begin
          state <= WAIT_RESET;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812b_rx.sv
// Scoreboard bench for ws2812b_rx: drives WS2812B waveforms, queues expected pixels, checks dout against delayed din.
`timescale 1ns/1ps
module tb_ws2812b_rx;
  import ws2812b_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        din = 1'b0;
  logic        dout;
  logic [23:0] pixel_data;
  logic        pixel_valid;
  logic        frame_end;
  logic        err;
  logic        rx_active;

  ws2812b_rx dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .dout        (dout),
    .pixel_data  (pixel_data),
    .pixel_valid (pixel_valid),
    .frame_end   (frame_end),
    .err         (err),
    .rx_active   (rx_active)
  );

  always #18 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  logic [23:0] exp_q[$];
  int pv_cnt = 0, fe_cnt = 0, err_cnt = 0, fe_err_cnt = 0, dout_bad = 0, dout_hi = 0;
  int fe_cyc = 0, err_cyc = 0, fall_cyc = 0, rise_cyc = 0;
  int pv0, fe0, er0, fee0, bad0, hi0, exp_hi;
  logic fwd_win = 1'b0;
  logic [2:0] din_h = 3'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    din_h <= {din_h[1:0], din};
  end

  // din_h[2] is din as driven three clock edges earlier
  always @(negedge clk) begin
    if (pixel_valid) begin
      pv_cnt <= pv_cnt + 1;
      if (exp_q.size() == 0) chk("pixel_unexpected", 32'd1, 32'd0);
      else chk("pixel_data", {8'h0, pixel_data}, {8'h0, exp_q.pop_front()});
    end
    if (dout !== (fwd_win ? din_h[2] : 1'b0)) dout_bad <= dout_bad + 1;
    if (dout) dout_hi <= dout_hi + 1;
    if (frame_end) begin
      fe_cnt <= fe_cnt + 1;
      fe_cyc <= cyc;
    end
    if (err) begin
      err_cnt <= err_cnt + 1;
      err_cyc <= cyc;
    end
    if (err && frame_end) fe_err_cnt <= fe_err_cnt + 1;
  end

  task automatic send_bit(input int h, input int l);
    din = 1'b1;
    rise_cyc = cyc;
    repeat (h) @(negedge clk);
    din = 1'b0;
    fall_cyc = cyc;
    repeat (l) @(negedge clk);
  endtask

  // Sends the top nbits of w MSB-first; h0 > 0 overrides the first bit's high time,
  // glitch_after >= 0 inserts a 2-cycle pulse after that many-plus-one bits.
  task automatic send_word(input logic [23:0] w, input int nbits, input int h0, input int glitch_after);
    for (int k = 0; k < nbits; k++) begin
      if (k == 0 && h0 > 0) send_bit(h0, 31 - h0);
      else send_bit(bit_high_cycles(w[23-k]), bit_low_cycles(w[23-k]));
      if (k == glitch_after) send_bit(2, 10);
    end
  endtask

  task automatic idle_low(input int n);
    din = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    pv0 = pv_cnt; fe0 = fe_cnt; er0 = err_cnt; fee0 = fe_err_cnt; bad0 = dout_bad; hi0 = dout_hi;
  endtask

  initial begin
    logic [23:0] w2;
    @(negedge clk);
    repeat (4) @(negedge clk);
    chk("rst_pixel_data", {8'h0, pixel_data}, 32'h0);
    chk("rst_pixel_valid", 32'(pixel_valid), 32'd0);
    chk("rst_frame_end", 32'(frame_end), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rx_active", 32'(rx_active), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    rst_n = 1'b1;
    idle_low(1100);

    // Single pixel, frame_end timing and silent dout
    snap();
    exp_q.push_back(24'h000505);
    send_word(24'h000505, 24, 0, -1);
    chk("t1_rx_active_mid", 32'(rx_active), 32'd1);
    idle_low(1100);
    chk("t1_pv", pv_cnt - pv0, 32'd1);
    chk("t1_fe", fe_cnt - fe0, 32'd1);
    chk("t1_err", err_cnt - er0, 32'd0);
    // fall on din reaches the FSM 2 cycles later, then RES_DET low cycles
    chk("t1_fe_delay", fe_cyc - fall_cyc, RES_DET + 2);
    chk("t1_rx_active_end", 32'(rx_active), 32'd0);
    chk("t1_dout", dout_bad - bad0, 32'd0);
    chk("t1_sb", exp_q.size(), 32'd0);

    // Two words in one frame: second is forwarded
    snap();
    exp_q.push_back(24'hA5A5A5);
    send_word(24'hA5A5A5, 24, 0, -1);
    fwd_win = 1'b1;
    send_word(24'h123456, 24, 0, -1);
    idle_low(1100);
    fwd_win = 1'b0;
    w2 = 24'h123456;
    exp_hi = 0;
    for (int i = 0; i < 24; i++) exp_hi += bit_high_cycles(w2[i]);
    chk("t2_pv", pv_cnt - pv0, 32'd1);
    chk("t2_fe", fe_cnt - fe0, 32'd1);
    chk("t2_err", err_cnt - er0, 32'd0);
    chk("t2_dout_exact", dout_bad - bad0, 32'd0);
    chk("t2_dout_high", dout_hi - hi0, exp_hi);
    chk("t2_hold", {8'h0, pixel_data}, 32'hA5A5A5);
    chk("t2_sb", exp_q.size(), 32'd0);

    // Bit threshold boundary on the first bit
    exp_q.push_back(24'h0F0F0F);
    send_word(24'h0F0F0F, 24, 13, -1);
    idle_low(1100);
    chk("t3_w13_b23", 32'(pixel_data[23]), 32'd0);
    exp_q.push_back(24'h8F0F0F);
    send_word(24'h0F0F0F, 24, 14, -1);
    idle_low(1100);
    chk("t3_w14_b23", 32'(pixel_data[23]), 32'd1);
    chk("t3_sb", exp_q.size(), 32'd0);

    // Glitch between bits 5 and 6
    snap();
    exp_q.push_back(24'h00FF00);
    send_word(24'h00FF00, 24, 0, 5);
    idle_low(1100);
    chk("t4_err", err_cnt - er0, 32'd1);
    chk("t4_pv", pv_cnt - pv0, 32'd1);
    chk("t4_sb", exp_q.size(), 32'd0);

    // Short frame
    snap();
    send_word(24'hABCDEF, 12, 0, -1);
    idle_low(1100);
    chk("t5_err_fe_same", fe_err_cnt - fee0, 32'd1);
    chk("t5_err", err_cnt - er0, 32'd1);
    chk("t5_fe", fe_cnt - fe0, 32'd1);
    chk("t5_pv", pv_cnt - pv0, 32'd0);
    chk("t5_hold", {8'h0, pixel_data}, 32'h00FF00);

    // Stuck high, then no decode until a full gap
    snap();
    send_bit(50, 500);
    chk("t6_stuck_err", err_cnt - er0, 32'd1);
    // 2 sync cycles, hi_cnt counts to T_HIGH_MAX, err registered one cycle later
    chk("t6_stuck_delay", err_cyc - rise_cyc, T_HIGH_MAX + 3);
    chk("t6_stuck_active", 32'(rx_active), 32'd0);
    send_word(24'h111111, 24, 0, -1);
    idle_low(1100);
    chk("t6_nodecode_pv", pv_cnt - pv0, 32'd0);
    chk("t6_nodecode_fe", fe_cnt - fe0, 32'd0);
    exp_q.push_back(24'h222222);
    send_word(24'h222222, 24, 0, -1);
    idle_low(1100);
    chk("t6_resume_pv", pv_cnt - pv0, 32'd1);
    chk("t6_sb", exp_q.size(), 32'd0);

    // Reset released mid-frame
    snap();
    send_word(24'h333333, 10, 0, -1);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("t7_rst_px", {8'h0, pixel_data}, 32'h0);
    rst_n = 1'b1;
    send_word(24'h3CCCCC, 14, 0, -1);
    send_word(24'h444444, 24, 0, -1);
    idle_low(1100);
    chk("t7_pv", pv_cnt - pv0, 32'd0);
    chk("t7_err", err_cnt - er0, 32'd0);
    chk("t7_fe", fe_cnt - fe0, 32'd0);
    exp_q.push_back(24'h555555);
    send_word(24'h555555, 24, 0, -1);
    idle_low(1100);
    chk("t7_pv_after_gap", pv_cnt - pv0, 32'd1);
    chk("t7_fe_after_gap", fe_cnt - fe0, 32'd1);
    chk("t7_sb", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
